// File: rtl/ace_ccu_pkg.sv
// Shared constants and types for the ACE CCU snoop request path.
package ace_ccu_pkg;

  localparam int DefaultNumOup        = 2;
  localparam int DefaultMaxTrans      = 4;
  localparam int DefaultTimeoutCycles = 1024;

  // Mask at the default port count; modules re-declare it at their own NumOup.
  typedef logic [DefaultNumOup-1:0] snoop_mask_t;

  // Pointer width for a ring of `depth` entries; a single entry still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ace_ccu_snoop_req_if.sv
// Handshake bundle between the snoop source, the snooper ports and the
// response stage. The slave modport is the distribution stage's view.
interface ace_ccu_snoop_req_if
  import ace_ccu_pkg::*;
#(
  parameter int  NumOup    = DefaultNumOup,
  parameter type ac_chan_t = logic
) ();

  logic              ac_valid_i;
  logic              ac_ready_o;
  ac_chan_t          ac_chan_i;
  logic [NumOup-1:0] ac_sel_i;
  logic [NumOup-1:0] ac_valids_o;
  logic [NumOup-1:0] ac_readies_i;
  ac_chan_t          ac_chans_o [NumOup];
  logic [NumOup-1:0] oup_sel_o;
  logic              oup_sel_valid_o;
  logic              oup_sel_ready_i;
  logic              err_o;

  modport slave (
    input  ac_valid_i, ac_chan_i, ac_sel_i, ac_readies_i, oup_sel_ready_i,
    output ac_ready_o, ac_valids_o, ac_chans_o, oup_sel_o, oup_sel_valid_o, err_o
  );

  modport master (
    output ac_valid_i, ac_chan_i, ac_sel_i, ac_readies_i, oup_sel_ready_i,
    input  ac_ready_o, ac_valids_o, ac_chans_o, oup_sel_o, oup_sel_valid_o, err_o
  );

endinterface

// File: rtl/ace_ccu_snoop_sel_fifo.sv
// In-order FIFO of snoop target masks for the response stage.
// Registered output (no fall-through), async active-high reset on control only.
module ace_ccu_snoop_sel_fifo
  import ace_ccu_pkg::*;
#(
  parameter int Width = DefaultNumOup,
  parameter int Depth = DefaultMaxTrans
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [Width-1:0] data_in,
  input  logic             pop,
  output logic [Width-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_width(Depth);
  localparam int CW = $clog2(Depth + 1);
  localparam logic [PW-1:0] LastPtr = PW'(Depth - 1);

  logic [Width-1:0] mem [Depth];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full     = (count == CW'(Depth));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign data_out = mem[rptr];

  // Pointer and occupancy bookkeeping; pointers wrap at Depth-1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == LastPtr) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == LastPtr) ? '0 : rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Mask storage; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= data_in;
  end

endmodule

// File: rtl/ace_ccu_snoop_req.sv
// Snoop request distribution: broadcasts one AC request to the selected
// snooper ports, retires it once every selected port has accepted, and
// queues the mask for the response combiner.
// Optional broadcast watchdog: ACE_CCU_SNOOP_REQ_TIMEOUT_EN.
module ace_ccu_snoop_req
  import ace_ccu_pkg::*;
#(
  parameter int  NumOup        = DefaultNumOup,
  parameter int  MaxTrans      = DefaultMaxTrans,
  parameter int  TimeoutCycles = DefaultTimeoutCycles,
  parameter type ac_chan_t     = logic
) (
  input logic               clk_i,
  input logic               rst_i,
  ace_ccu_snoop_req_if.slave bus
);

  typedef logic [NumOup-1:0] mask_t;

  mask_t done;
  mask_t hs;
  logic  fifo_full, fifo_empty;
  logic  enable;
  logic  retire;

  // Admission looks only at the registered FIFO occupancy, so a pop this
  // cycle frees a slot for the next cycle, never the current one.
  assign enable = ~rst_i & ~fifo_full;

  assign bus.ac_valids_o = {NumOup{bus.ac_valid_i & enable}} & bus.ac_sel_i & ~done;
  assign hs              = bus.ac_valids_o & bus.ac_readies_i;
  assign retire          = bus.ac_valid_i & enable & ((done | hs) == bus.ac_sel_i);
  assign bus.ac_ready_o  = retire;

  for (genvar j = 0; j < NumOup; j++) begin : g_chan
    assign bus.ac_chans_o[j] = bus.ac_chan_i;
  end

  // Remember which ports already accepted so they are not presented again.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       done <= '0;
    else if (retire) done <= '0;
    else             done <= done | hs;
  end

  ace_ccu_snoop_sel_fifo #(
    .Width (NumOup),
    .Depth (MaxTrans)
  ) u_sel_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (retire),
    .data_in  (bus.ac_sel_i),
    .pop      (bus.oup_sel_ready_i),
    .data_out (bus.oup_sel_o),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.oup_sel_valid_o = ~fifo_empty;

`ifdef ACE_CCU_SNOOP_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [TW-1:0] TLimit = TW'(TimeoutCycles);

  logic [TW-1:0] tcnt;
  logic          pending;
  logic          err;

  assign pending   = bus.ac_valid_i & enable & ~retire;
  assign bus.err_o = err;

  // Watchdog: count stalled broadcast cycles; flag is sticky until reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (retire)                        tcnt <= '0;
      else if (pending && tcnt != TLimit) tcnt <= tcnt + 1'b1;
      if (pending && tcnt >= TLimit - 1'b1) err <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TimeoutCycles;
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ace_ccu_snoop_req.sv
// Bench for ace_ccu_snoop_req: table of per-cycle vectors plus hand-written
// reset and watchdog sequences; the mask queue is checked by a scoreboard.
module tb_ace_ccu_snoop_req;

  logic clk;
  logic rst;

  ace_ccu_snoop_req_if #(.NumOup(2), .ac_chan_t(logic [7:0])) bus ();

  ace_ccu_snoop_req #(
    .NumOup        (2),
    .MaxTrans      (4),
    .TimeoutCycles (8),
    .ac_chan_t     (logic [7:0])
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic [1:0] rdy;
    logic       oupr;
    logic [1:0] ev;
    logic       er;
    string      nm;
  } vec_t;

  vec_t       tbl [$];
  logic [1:0] sbq [$];
  int         checks   = 0;
  int         failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic v, input logic [1:0] sel, input logic [1:0] rdy,
                              input logic oupr, input logic [1:0] ev, input logic er,
                              input string nm);
    vec_t r;
    r.v = v; r.sel = sel; r.rdy = rdy; r.oupr = oupr; r.ev = ev; r.er = er; r.nm = nm;
    tbl.push_back(r);
  endfunction

  // One clock cycle: drive at the falling edge, check mid-cycle, update scoreboard.
  task automatic cyc(input logic v, input logic [1:0] sel, input logic [1:0] rdy,
                     input logic oupr, input logic [1:0] ev, input logic er,
                     input logic ee, input string nm);
    logic [7:0] pay;
    logic       exp_ov;
    @(negedge clk);
    pay = 8'($urandom);
    bus.ac_valid_i      = v;
    bus.ac_sel_i        = sel;
    bus.ac_readies_i    = rdy;
    bus.oup_sel_ready_i = oupr;
    bus.ac_chan_i       = pay;
    #1;
    chk({nm, " ac_valids"}, 32'(bus.ac_valids_o), 32'(ev));
    chk({nm, " ac_ready"},  32'(bus.ac_ready_o),  32'(er));
    chk({nm, " err"},       32'(bus.err_o),       32'(ee));
    chk({nm, " chan0"},     32'(bus.ac_chans_o[0]), 32'(pay));
    chk({nm, " chan1"},     32'(bus.ac_chans_o[1]), 32'(pay));
    exp_ov = (sbq.size() != 0);
    chk({nm, " oup_sel_valid"}, 32'(bus.oup_sel_valid_o), 32'(exp_ov));
    if (exp_ov && oupr) begin
      chk({nm, " oup_sel"}, 32'(bus.oup_sel_o), 32'(sbq[0]));
      void'(sbq.pop_front());
    end
    if (er) sbq.push_back(sel);
  endtask

  initial begin
    rst                 = 1'b1;
    bus.ac_valid_i      = 1'b1;
    bus.ac_sel_i        = 2'b11;
    bus.ac_readies_i    = 2'b11;
    bus.oup_sel_ready_i = 1'b0;
    bus.ac_chan_i       = '0;

    // Reset state with a request already pending at the input.
    @(negedge clk); #1;
    chk("reset ac_valids",     32'(bus.ac_valids_o),     32'(0));
    chk("reset ac_ready",      32'(bus.ac_ready_o),      32'(0));
    chk("reset oup_sel_valid", 32'(bus.oup_sel_valid_o), 32'(0));
    chk("reset err",           32'(bus.err_o),           32'(0));
    @(negedge clk);
    bus.ac_valid_i = 1'b0;
    rst = 1'b0;

    // v, sel, rdy, oupr, exp valids, exp ready
    add(0, 2'b11, 2'b11, 0, 2'b00, 0, "idle");
    add(1, 2'b11, 2'b11, 0, 2'b11, 1, "bcast_both");
    add(0, 2'b00, 2'b00, 1, 2'b00, 0, "drain_a");
    add(1, 2'b11, 2'b01, 0, 2'b11, 0, "split_c0");
    add(1, 2'b11, 2'b00, 0, 2'b10, 0, "split_c1");
    add(1, 2'b11, 2'b00, 0, 2'b10, 0, "split_c2");
    add(1, 2'b11, 2'b10, 0, 2'b10, 1, "split_c3");
    add(0, 2'b00, 2'b00, 1, 2'b00, 0, "drain_b");
    add(1, 2'b01, 2'b11, 0, 2'b01, 1, "ord_01");
    add(1, 2'b10, 2'b11, 0, 2'b10, 1, "ord_10");
    add(1, 2'b00, 2'b11, 0, 2'b00, 1, "ord_00");
    add(1, 2'b11, 2'b11, 0, 2'b11, 1, "ord_11");
    add(1, 2'b01, 2'b11, 0, 2'b00, 0, "full_block");
    add(1, 2'b01, 2'b11, 1, 2'b00, 0, "full_pop_same");
    add(1, 2'b01, 2'b11, 0, 2'b01, 1, "full_admit_next");
    for (int i = 0; i < 5; i++) add(0, 2'b00, 2'b00, 1, 2'b00, 0, "drain_c");

    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].v, tbl[i].sel, tbl[i].rdy, tbl[i].oupr, tbl[i].ev, tbl[i].er, 1'b0, tbl[i].nm);

    // Reset in the middle of a broadcast after port 0 accepted.
    cyc(1, 2'b11, 2'b01, 0, 2'b11, 0, 0, "rst_pre");
    @(negedge clk);
    rst = 1'b1;
    bus.ac_readies_i = 2'b00;
    #1;
    chk("midrst ac_valids",     32'(bus.ac_valids_o),     32'(0));
    chk("midrst ac_ready",      32'(bus.ac_ready_o),      32'(0));
    chk("midrst oup_sel_valid", 32'(bus.oup_sel_valid_o), 32'(0));
    chk("midrst err",           32'(bus.err_o),           32'(0));
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 2'b11, 2'b00, 0, 2'b11, 0, 0, "rst_rebcast");
    cyc(1, 2'b11, 2'b11, 0, 2'b11, 1, 0, "rst_retire");
    cyc(0, 2'b00, 2'b00, 1, 2'b00, 0, 0, "rst_drain");

`ifdef ACE_CCU_SNOOP_REQ_TIMEOUT_EN
    // Port 1 stalls for eight pending cycles; flag must stick past the retire.
    cyc(1, 2'b11, 2'b01, 0, 2'b11, 0, 0, "to_c1");
    for (int i = 2; i <= 8; i++) cyc(1, 2'b11, 2'b00, 0, 2'b10, 0, 0, "to_wait");
    cyc(1, 2'b11, 2'b10, 0, 2'b10, 1, 1, "to_retire");
    cyc(0, 2'b00, 2'b00, 1, 2'b00, 0, 1, "to_sticky");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ace_ccu_snoop_req.md
Name: ace_ccu_snoop_req

Overview:
- Snoop request distribution stage, directly upstream of the CCU snoop response combiner.
- Takes one AC snoop request plus a target mask and broadcasts it to the selected snooper ports.
- Tracks per-port AC handshakes and retires the request only when every selected port has accepted.
- Queues the target mask in order so the response stage knows which CR/CD ports to join for each snoop.

Parameters:
- NumOup, 2, number of snooper ports (>=1).
- MaxTrans, 4, outstanding snoops whose mask is queued and awaiting the response stage (>=1; power of two not required).
- TimeoutCycles, 1024, per-request broadcast watchdog limit (used only with the optional feature).
- ac_chan_t, logic, AC snoop request channel type.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- ac_valid_i  in  1  upstream snoop request valid.
- ac_ready_o  out  1  upstream snoop request ready.
- ac_chan_i  in  ac_chan_t  snoop request payload.
- ac_sel_i  in  NumOup  target port mask, qualified by ac_valid_i.
- ac_valids_o  out  NumOup  per-port AC valid.
- ac_readies_i  in  NumOup  per-port AC ready.
- ac_chans_o  out  NumOup x ac_chan_t  per-port payload, all equal to ac_chan_i.
- oup_sel_o  out  NumOup  queued mask sent to the response stage.
- oup_sel_valid_o  out  1  queued mask valid.
- oup_sel_ready_i  in  1  response stage consumed the mask.
- err_o  out  1  sticky watchdog error; tied 0 when the optional feature is off.

Behaviour:
- Reset values (rst_i high, async): done mask 0, FIFO count/wptr/rptr 0, all ac_valids_o 0, ac_ready_o 0, oup_sel_valid_o 0, err_o 0. A reset mid-broadcast aborts the request and clears all partial acceptance state.
- Upstream protocol: ac_chan_i and ac_sel_i stay stable while ac_valid_i is high and ac_ready_o is low.
- Admission: broadcast is enabled only when FIFO count < MaxTrans at cycle start. When full, ac_valids_o = 0 and ac_ready_o = 0. A pop in the same cycle does not admit a new request; the freed slot is usable the next cycle.
- Broadcast: ac_valids_o[j] = ac_valid_i & enable & ac_sel_i[j] & ~done[j]. This is combinational, zero cycles.
- done[j] is set on each per-port handshake and cleared on retire.
- Retire condition: (done | (ac_valids_o & ac_readies_i)) == ac_sel_i. In the retire cycle:
  - ac_ready_o = 1;
  - ac_sel_i is pushed to the FIFO;
  - done clears to 0.
- Ports may accept in any order and in any cycles. Each port sees exactly one handshake per request; it is never re-presented after it accepts.
- Empty mask (ac_sel_i = 0) with a FIFO slot free: retires in the same cycle and pushes an all-zero mask.
- FIFO:
  - Registered, no fall-through.
  - oup_sel_valid_o rises the cycle after a push into an empty FIFO.
  - Pop on oup_sel_valid_o & oup_sel_ready_i.
  - A simultaneous push and pop keeps count unchanged.
  - Pointers wrap at MaxTrans-1 -> 0.
  - Masks are output in strict push order.
- count width is $clog2(MaxTrans+1); it never exceeds MaxTrans.

Optional Feature:
- Macro: ACE_CCU_SNOOP_REQ_TIMEOUT_EN.
- With the macro defined:
  - A $clog2(TimeoutCycles+1)-bit counter increments each cycle that ac_valid_i & enable is high without a retire.
  - The counter resets to 0 on retire.
  - When it reaches TimeoutCycles, err_o sets and stays set until reset. Traffic is not altered.
- Without the macro: the counter logic is absent and err_o is constant 0.

Decomposition:
- Shared package ace_ccu_pkg holds:
  - the snoop mask typedef, parameterised by NumOup through the module's local typedef;
  - the default MaxTrans and TimeoutCycles constants.
- One natural sub-module: ace_ccu_snoop_sel_fifo. It is the mask FIFO with push, pop, full and empty flags and async active-high reset.

Test Plan:
- NumOup=2, mask 2'b11, both readies high -> ac_valids_o = 2'b11 in the same cycle, ac_ready_o = 1, oup_sel_o = 2'b11 valid on the next cycle.
- Mask 2'b11, port0 ready in cycle 0, port1 ready in cycle 3 -> ac_valids_o = 2'b10 in cycles 1-3, ac_ready_o only in cycle 3, one FIFO push.
- MaxTrans=4, oup_sel_ready_i = 0, 5 requests -> 4 retire, the 5th sees ac_valids_o = 0. Popping one mask admits it on the following cycle, not the same cycle.
- Masks 01, 10, 00, 11 pushed -> oup_sel_o pops 01, 10, 00, 11 in order. The 00 request retires in one cycle.
- rst_i asserted while done = 2'b01 -> all outputs 0 immediately. After release, the same request re-broadcasts to both ports.
- With ACE_CCU_SNOOP_REQ_TIMEOUT_EN and TimeoutCycles=8, port1 ready held low -> err_o = 1 after 8 pending cycles and stays 1 after the later retire.
